// File: rtl/x3_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the
// excess-3 serial adder.
package x3_pkg;

  localparam logic [3:0] XS3_BIAS = 4'd3;
  localparam logic [3:0] XS3_MIN  = 4'd3;
  localparam logic [3:0] XS3_MAX  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic xs3_valid(input logic [3:0] digit);
    return (digit >= XS3_MIN) && (digit <= XS3_MAX);
  endfunction

endpackage

// File: rtl/x3_digit_add.sv
// Combinational single-digit excess-3 add: binary sum, then re-bias by +3
// on decimal carry or -3 otherwise (mod-16 wrap for out-of-range digits).
module x3_digit_add
  import x3_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] x,
  output logic       co,
  output logic       bad
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    co  = sum[4];
    x   = co ? (sum[3:0] + XS3_BIAS) : (sum[3:0] - XS3_BIAS);
    bad = !xs3_valid(a) || !xs3_valid(b);
  end

endmodule

// File: rtl/x3_serial_adder.sv
// Multi-digit excess-3 adder, one digit per clock LSD first, with
// valid/ready handshakes on operand and result sides.
module x3_serial_adder
  import x3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] x,
  output logic              cout,
  output logic              err,
  output logic              busy
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  x_q, x_d;

  logic [3:0]    dig_x;
  logic          dig_co;
  logic          dig_bad;
  logic [W-1:0]  a_shifted, b_shifted, x_shifted;

  x3_digit_add u_digit (
    .a   (a_sh_q[3:0]),
    .b   (b_sh_q[3:0]),
    .ci  (carry_q),
    .x   (dig_x),
    .co  (dig_co),
    .bad (dig_bad)
  );

  // Operands drain from the bottom; results enter from the top so that
  // after NDIG shifts digit 0 lands in [3:0].
  generate
    if (NDIG == 1) begin : g_one
      assign a_shifted = '0;
      assign b_shifted = '0;
      assign x_shifted = dig_x;
    end else begin : g_multi
      assign a_shifted = {4'b0, a_sh_q[W-1:4]};
      assign b_shifted = {4'b0, b_sh_q[W-1:4]};
      assign x_shifted = {dig_x, x_q[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    err_d   = err_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d     = x_shifted;
        carry_d = dig_co;
        a_sh_d  = a_shifted;
        b_sh_d  = b_shifted;
        err_d   = err_q | dig_bad;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      x_q     <= x_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign x         = x_q;
  assign cout      = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_x3_serial_adder.sv
// Directed-vector bench for the excess-3 serial adder (NDIG=4).
module tb_x3_serial_adder;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic        cout;
  logic        err;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  x3_serial_adder #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .cout      (cout),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready (bounded), then presents operands for one accepted edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, output bit ok);
    int n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    ok = in_ready;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the acceptance edge until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid) return;
    end
    lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready got=%b want=0", in_ready); miscompares++;
    end
    vectors++;
    if ({out_valid, busy, cout, err, x} !== 20'h0) begin
      $display("FAIL reset_outputs got ov=%b busy=%b cout=%b err=%b x=%h want all 0",
               out_valid, busy, cout, err, x); miscompares++;
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready); miscompares++;
    end
    $display("test_reset: done");
  endtask

  task automatic test_add(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] xe, input logic ce,
                          input logic ee);
    bit ok;
    int lat;
    start_op(av, bv, cv, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL %s_accept in_ready never rose", name); miscompares++;
    end
    wait_done(lat);
    vectors++;
    if (lat != NDIG) begin
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, NDIG); miscompares++;
    end
    vectors++;
    if ({x, cout, err} !== {xe, ce, ee}) begin
      $display("FAIL %s_result got x=%h cout=%b err=%b want x=%h cout=%b err=%b",
               name, x, cout, err, xe, ce, ee); miscompares++;
    end
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1",
               name, out_valid, in_ready); miscompares++;
    end
    $display("%s: a=%h b=%h cin=%b -> x=%h cout=%b err=%b lat=%0d",
             name, av, bv, cv, x, cout, err, lat);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    start_op(16'h3333, 16'h3333, 1'b1, ok);
    // Attempt a second capture while RUN is in progress.
    a = 16'hCCCC; b = 16'hCCCC; cin = 1'b0; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bp_run_flags got ir=%b busy=%b want ir=0 busy=1", in_ready, busy);
      miscompares++;
    end
    wait_done(lat);
    vectors++;
    if (lat != NDIG) begin
      $display("FAIL bp_latency got=%0d want=%0d", lat, NDIG); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({out_valid, in_ready, x, cout, err} !== {1'b1, 1'b0, 16'h3334, 1'b0, 1'b0}) begin
        $display("FAIL bp_hold_%0d got ov=%b ir=%b x=%h cout=%b err=%b want ov=1 ir=0 x=3334 cout=0 err=0",
                 i, out_valid, in_ready, x, cout, err); miscompares++;
      end
      tick();
    end
    in_valid = 1'b0;
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      miscompares++;
    end
    $display("test_backpressure: x=%h held 3 cycles", 16'h3334);
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_op(16'h4567, 16'h89AB, 1'b0, ok);
    tick();  // first RUN edge done; now in RUN cycle 2
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL midrst_in_ready_during got=%b want=0", in_ready); miscompares++;
    end
    tick();
    vectors++;
    if ({out_valid, busy, cout, err, x} !== 20'h0) begin
      $display("FAIL midrst_outputs got ov=%b busy=%b cout=%b err=%b x=%h want all 0",
               out_valid, busy, cout, err, x); miscompares++;
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL midrst_idle got ir=%b want=1", in_ready); miscompares++;
    end
    $display("test_reset_mid: reset during RUN returned to IDLE");
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int nres = 0;
    int acc_cyc[2];
    logic [15:0] res[2];
    bit accepted;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    res[0] = '0; res[1] = '0;
    out_ready = 1'b1;
    a = 16'h4567; b = 16'h89AB; cin = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      accepted = in_ready && in_valid;
      tick();
      if (accepted && acc < 2) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == 1) begin
          a = 16'hCCCC; b = 16'h3334;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && nres < 2) begin
        res[nres] = x;
        nres++;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (acc != 2 || (acc_cyc[1] - acc_cyc[0]) != NDIG + 2) begin
      $display("FAIL b2b_spacing got acc=%0d gap=%0d want acc=2 gap=%0d",
               acc, acc_cyc[1] - acc_cyc[0], NDIG + 2); miscompares++;
    end
    vectors++;
    if (nres != 2 || res[0] !== 16'h9C45 || res[1] !== 16'h3333) begin
      $display("FAIL b2b_results got n=%0d r0=%h r1=%h want n=2 r0=9c45 r1=3333",
               nres, res[0], res[1]); miscompares++;
    end
    $display("test_back_to_back: gap=%0d r0=%h r1=%h", acc_cyc[1] - acc_cyc[0], res[0], res[1]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    test_reset();
    // 1234 + 5678 = 6912 -> XS-3 9C45
    test_add("test_basic",  16'h4567, 16'h89AB, 1'b0, 16'h9C45, 1'b0, 1'b0);
    test_add("test_ripple", 16'hCCCC, 16'h3334, 1'b0, 16'h3333, 1'b1, 1'b0);
    test_add("test_cin",    16'h3333, 16'h3333, 1'b1, 16'h3334, 1'b0, 1'b0);
    test_add("test_err",    16'h0333, 16'h3333, 1'b0, 16'h0333, 1'b0, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_add("test_after_reset", 16'h4567, 16'h89AB, 1'b0, 16'h9C45, 1'b0, 1'b0);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
